// File: rtl/key_event_pkg.sv
// Shared event codes, per-key FSM states and sizing helper for the key event controller.
package key_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        LONG,
        RELEASE_WAIT
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_fsm.sv
// One key: 2-flop synchroniser, tick-based debounce/long-press FSM, registered level and event strobes.
// Strobes are one-cycle pulses on the edge the FSM changes state; KEY_AUTO_REPEAT_EN adds REPEAT in LONG.
module key_fsm
    import key_event_pkg::*;
#(
    parameter int DB_TICKS     = 3,
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    input  logic tick,
    output logic level,
    output logic evt_press,
    output logic evt_release,
    output logic evt_long,
    output logic evt_repeat
);
    localparam int CNT_MAX = max3(DB_TICKS, LONG_TICKS, REPEAT_TICKS);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DB_C   = CW'(DB_TICKS);
    localparam logic [CW-1:0] LONG_C = CW'(LONG_TICKS);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_C  = CW'(REPEAT_TICKS);
`endif

    logic          sync1_q, sync2_q;
    key_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          level_q, press_q, rel_q, long_q, rep_q;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            case (state_q)
                IDLE: if (sync2_q) begin
                    state_q <= PRESS_WAIT;
                    cnt_q   <= '0;
                end
                PRESS_WAIT: if (!sync2_q) begin
                    state_q <= IDLE;
                end else if (tick) begin
                    if (cnt_inc == DB_C) begin
                        state_q <= HELD;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: if (!sync2_q) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= '0;
                end else if (tick) begin
                    if (cnt_inc == LONG_C) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                LONG: if (!sync2_q) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= '0;
                end
`ifdef KEY_AUTO_REPEAT_EN
                else if (tick) begin
                    if (cnt_inc == REP_C) begin
                        rep_q <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
`endif
                // A bounce back high during release resumes HELD with a fresh long timer.
                RELEASE_WAIT: if (sync2_q) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                end else if (tick) begin
                    if (cnt_inc == DB_C) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                        rel_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level       = level_q;
    assign evt_press   = press_q;
    assign evt_release = rel_q;
    assign evt_long    = long_q;
    assign evt_repeat  = rep_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces NUM_KEYS pushbuttons on a shared tick and serialises their events round-robin onto one stream.
// Event to evt_valid is 2 clk; while stalled the output holds and new events merge into pending bits (ovf if lost).
// Optional auto-repeat in the LONG state is enabled by KEY_AUTO_REPEAT_EN.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int  NUM_KEYS     = 4,
    parameter int  TICK_DIV     = 20,
    parameter int  DB_TICKS     = 3,
    parameter int  LONG_TICKS   = 50,
    parameter int  REPEAT_TICKS = 10,
    localparam int KW           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] sw,
    output logic [NUM_KEYS-1:0] level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KW-1:0]       evt_key,
    output logic [1:0]          evt_code,
    output logic [NUM_KEYS-1:0] ovf
);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [3:0] CODE_MASK = 4'b1111;
`else
    localparam logic [3:0] CODE_MASK = 4'b0111;
`endif

    logic [TICK_DIV-1:0]       presc_q;
    logic                      tick;
    logic [NUM_KEYS-1:0][3:0]  raise, pend_q, pend_d, clr, avail;
    logic [NUM_KEYS-1:0]       ovf_q, ovf_d;
    logic                      evt_valid_q;
    logic [KW-1:0]             evt_key_q, ptr_q, sel_key;
    evt_code_t                 evt_code_q, sel_code;
    logic                      sel_vld;
    int                        idx;

    assign tick = (presc_q == '0);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_fsm #(
            .DB_TICKS    (DB_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_key (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw[k]),
            .tick       (tick),
            .level      (level[k]),
            .evt_press  (raise[k][EVT_PRESS]),
            .evt_release(raise[k][EVT_RELEASE]),
            .evt_long   (raise[k][EVT_LONG]),
            .evt_repeat (raise[k][EVT_REPEAT])
        );
    end

    // A fresh event on a bit cleared by this cycle's handshake is a new event, not a loss.
    always_comb begin
        clr = '0;
        if (evt_valid_q && evt_ready) clr[evt_key_q][evt_code_q] = 1'b1;
        for (int k = 0; k < NUM_KEYS; k++) begin
            avail[k]  = pend_q[k] & ~clr[k];
            pend_d[k] = (avail[k] | raise[k]) & CODE_MASK;
            ovf_d[k]  = ovf_q[k] | (|(raise[k] & avail[k] & CODE_MASK));
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_key  = '0;
        sel_code = EVT_PRESS;
        idx      = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
            if (!sel_vld && (|avail[idx])) begin
                sel_vld = 1'b1;
                sel_key = KW'(idx);
                if      (avail[idx][EVT_PRESS])  sel_code = EVT_PRESS;
                else if (avail[idx][EVT_LONG])   sel_code = EVT_LONG;
                else if (avail[idx][EVT_REPEAT]) sel_code = EVT_REPEAT;
                else                             sel_code = EVT_RELEASE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_code_q  <= EVT_PRESS;
            ptr_q       <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            if (!evt_valid_q || evt_ready) begin
                evt_valid_q <= sel_vld;
                if (sel_vld) begin
                    evt_key_q  <= sel_key;
                    evt_code_q <= sel_code;
                    ptr_q      <= (int'(sel_key) == NUM_KEYS - 1) ? '0 : sel_key + 1'b1;
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_code  = evt_code_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a 16-cycle tick, DB=3, LONG=4, REPEAT=2 and four keys.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       evt_ready = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic [3:0] level, ovf;
    logic       evt_valid;
    logic [1:0] evt_key, evt_code;

    typedef struct {
        logic [1:0] key;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t ev_q[$];
    int  rd = 0;
    int  cyc = 0;
    int  nvec = 0;
    int  nerr = 0;

    key_event_ctrl #(
        .NUM_KEYS    (4),
        .TICK_DIV    (4),
        .DB_TICKS    (3),
        .LONG_TICKS  (4),
        .REPEAT_TICKS(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .level    (level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_code (evt_code),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted events are logged half a cycle before the accepting edge.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            e.key  = evt_key;
            e.code = evt_code;
            e.cyc  = cyc;
            ev_q.push_back(e);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
        nvec++;
        assert (v >= lo && v <= hi) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic wait_level(input string tag, input int k, input logic val, input int budget, output int n);
        n = 0;
        while (level[k] !== val && n < budget) begin
            step();
            n++;
        end
        chk(tag, level[k], val);
    endtask

    task automatic wait_ev(input int n, input int budget);
        for (int i = 0; i < budget && ev_q.size() < rd + n; i++) step();
    endtask

    task automatic chk_ev(input string tag, input int key, input int code, output int c);
        c = -1000;
        nvec++;
        assert (rd < ev_q.size()) else begin
            nerr++;
            $error("FAIL %s: observed %0d events, expected more than %0d", tag, ev_q.size(), rd);
        end
        if (rd < ev_q.size()) begin
            chk({tag, "_key"}, ev_q[rd].key, key);
            chk({tag, "_code"}, ev_q[rd].code, code);
            c = ev_q[rd].cyc;
            rd++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        int n, c, c0, lvl_c, fall_c;

        // Reset values
        step(3);
        chk("rst_level", level, 4'b0000);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_key", evt_key, 2'd0);
        chk("rst_code", evt_code, 2'd0);
        chk("rst_ovf", ovf, 4'b0000);
        reset = 1'b0;
        evt_ready = 1'b1;
        step(2);

        // 20-cycle glitch on key 0 never reaches HELD
        sw = 4'b0001;
        step(20);
        sw = 4'b0000;
        step(80);
        chk("glitch_level", level, 4'b0000);
        chk("glitch_events", ev_q.size(), rd);
        chk("glitch_ovf", ovf, 4'b0000);

        // Key 1 long hold: PRESS, LONG (+REPEATs), RELEASE
        sw = 4'b0010;
        wait_level("k1_rise", 1, 1'b1, 60, n);
        chk_rng("k1_rise_dly", n, 36, 51);
        chk("k1_level", level, 4'b0010);
        lvl_c = cyc;
        wait_ev(1, 10);
        chk_ev("k1_press", 1, 0, c);
        chk("k1_press_cyc", c, lvl_c + 2);
        wait_ev(1, 80);
        chk_ev("k1_long", 1, 2, c);
        chk("k1_long_cyc", c, lvl_c + 66);
`ifdef KEY_AUTO_REPEAT_EN
        wait_ev(1, 40);
        chk_ev("k1_rep1", 1, 3, c);
        chk("k1_rep1_cyc", c, lvl_c + 98);
        wait_ev(1, 40);
        chk_ev("k1_rep2", 1, 3, c);
        chk("k1_rep2_cyc", c, lvl_c + 130);
`endif
        for (int i = 0; i < 300 && cyc < lvl_c + 150; i++) step();
        sw = 4'b0000;
        wait_level("k1_fall", 1, 1'b0, 60, n);
        chk_rng("k1_fall_dly", n, 36, 51);
        fall_c = cyc;
        wait_ev(1, 10);
        chk_ev("k1_release", 1, 1, c);
        chk("k1_release_cyc", c, fall_c + 2);
        step(100);
        chk("k1_no_extra", ev_q.size(), rd);
        chk("k1_ovf", ovf, 4'b0000);

        // Round robin between keys 0 and 2
        do_reset();
        sw = 4'b0101;
        wait_ev(2, 80);
        chk_ev("rr_a0", 0, 0, c0);
        chk_ev("rr_a1", 2, 0, c);
        chk("rr_a_b2b", c, c0 + 1);
        sw = 4'b0000;
        wait_ev(2, 80);
        chk_ev("rr_b0", 0, 1, c0);
        chk_ev("rr_b1", 2, 1, c);
        chk("rr_b_b2b", c, c0 + 1);
        sw = 4'b0001;
        wait_ev(1, 80);
        chk_ev("rr_c0", 0, 0, c0);
        sw = 4'b0100;
        wait_ev(2, 80);
        chk_ev("rr_d0", 2, 0, c0);
        chk_ev("rr_d1", 0, 1, c);
        chk("rr_d_b2b", c, c0 + 1);
        sw = 4'b0000;
        wait_ev(1, 80);
        chk_ev("rr_e0", 2, 1, c);

        // Stalled output on key 3: press, release, press
        evt_ready = 1'b0;
        sw = 4'b1000;
        wait_level("k3_rise1", 3, 1'b1, 60, n);
        step(3);
        chk("stall_vld1", evt_valid, 1'b1);
        chk("stall_key1", evt_key, 2'd3);
        chk("stall_code1", evt_code, 2'd0);
        sw = 4'b0000;
        wait_level("k3_fall1", 3, 1'b0, 60, n);
        step(3);
        chk("stall_key2", evt_key, 2'd3);
        chk("stall_code2", evt_code, 2'd0);
        chk("stall_ovf2", ovf, 4'b0000);
        sw = 4'b1000;
        wait_level("k3_rise2", 3, 1'b1, 60, n);
        step(3);
        chk("stall_ovf3", ovf, 4'b1000);
        chk("stall_vld3", evt_valid, 1'b1);
        chk("stall_code3", evt_code, 2'd0);
        evt_ready = 1'b1;
        wait_ev(2, 10);
        chk_ev("drain0", 3, 0, c0);
        chk_ev("drain1", 3, 1, c);
        chk("drain_b2b", c, c0 + 1);
        step(3);
        chk("drain_idle", evt_valid, 1'b0);
        sw = 4'b0000;
        wait_ev(1, 80);
        chk_ev("k3_release", 3, 1, c);
        chk("ovf_sticky", ovf, 4'b1000);

        // Reset mid-PRESS_WAIT with an event presented
        evt_ready = 1'b0;
        sw = 4'b0010;
        for (int i = 0; i < 80 && evt_valid !== 1'b1; i++) step();
        chk("pre_rst_vld", evt_valid, 1'b1);
        sw = 4'b0110;
        step(10);
        reset = 1'b1;
        sw = 4'b0000;
        #2;
        chk("arst_level", level, 4'b0000);
        chk("arst_valid", evt_valid, 1'b0);
        chk("arst_key", evt_key, 2'd0);
        chk("arst_code", evt_code, 2'd0);
        chk("arst_ovf", ovf, 4'b0000);
        step(2);
        reset = 1'b0;
        evt_ready = 1'b1;
        step(120);
        chk("post_rst_events", ev_q.size(), rd);
        chk("post_rst_valid", evt_valid, 1'b0);
        chk("post_rst_level", level, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Front-end controller for the board's pushbuttons.
- Debounces NUM_KEYS raw inputs against one shared sample-tick prescaler, so there is a single tick counter for all keys.
- Classifies each key's activity into press, release, long-press and auto-repeat events.
- Serialises all events onto a single valid/ready event stream using a round-robin arbiter, for consumption by the top-level game/menu FSM.

Parameters:
- NUM_KEYS, 4, number of raw key inputs (1..8).
- TICK_DIV, 20, prescaler width; one sample tick every 2^TICK_DIV clk cycles.
- DB_TICKS, 3, ticks an input must be stable to change debounced level (>=1).
- LONG_TICKS, 50, ticks held before the long-press event (>=1).
- REPEAT_TICKS, 10, ticks between auto-repeat events after a long press (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sw  in  NUM_KEYS  raw, asynchronous key inputs, active high.
- level  out  NUM_KEYS  debounced key levels.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_key  out  $clog2(NUM_KEYS) (min 1)  index of the key that raised the event.
- evt_code  out  2  event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- ovf  out  NUM_KEYS  sticky per-key "event lost" flag.

Behaviour:
- Reset (async, active-high) sets the following:
  - prescaler, all key FSMs to IDLE, all per-key counters, pending bits, level, evt_valid, evt_key, evt_code and ovf all to 0.
- Synchroniser and prescaler:
  - Each sw bit passes through a 2-flop synchroniser; s[k] denotes the synchronised value.
  - The prescaler is a free-running TICK_DIV-bit up-counter.
  - tick is high for one cycle whenever the count equals 0.
- Per-key FSM, with tick counter cnt (sized for the largest of DB_TICKS, LONG_TICKS, REPEAT_TICKS):
  - IDLE: if s=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - if s=0, go to IDLE;
    - else on tick, cnt++;
    - on the tick where cnt reaches DB_TICKS, go to HELD, set level=1, raise PRESS, set cnt=0.
  - HELD:
    - if s=0, go to RELEASE_WAIT and set cnt=0;
    - else on tick, cnt++;
    - on reaching LONG_TICKS, go to LONG, raise LONG, set cnt=0.
  - LONG:
    - if s=0, go to RELEASE_WAIT and set cnt=0;
    - else on tick, cnt++;
    - on reaching REPEAT_TICKS, raise REPEAT and set cnt=0 (see Optional Feature).
  - RELEASE_WAIT:
    - if s=1, go to HELD and set cnt=0; the long timer restarts and no event is raised;
    - else on tick, cnt++;
    - on reaching DB_TICKS, go to IDLE, set level=0, raise RELEASE.
  - Any s change before the final tick aborts the wait, so glitches produce no event.
  - Tick quantisation: effective debounce time lies between (DB_TICKS-1)·2^TICK_DIV and DB_TICKS·2^TICK_DIV cycles. This is intended.
- Pending store:
  - One bit per key per code.
  - A raised event sets its bit.
  - If the bit is already set and is not being cleared by a handshake in the same cycle, ovf[k] is set (sticky until reset) and the event merges into the existing bit.
  - A set and a clear of the same bit in the same cycle: the set wins (bit stays 1, no overflow).
- Arbiter and output register:
  - evt_valid, evt_key and evt_code are registered.
  - While evt_valid=1 and evt_ready=0, all three are held stable; new events only accumulate as pending bits.
  - On the cycle evt_valid&evt_ready is high, the presented pending bit clears, and on the same edge the next selection is loaded. Back-to-back events need no bubble.
  - If nothing is pending, evt_valid goes low.
  - Key selection is round-robin, starting at (last granted key + 1) mod NUM_KEYS. After reset the search starts at key 0.
  - Within a key, priority is PRESS > LONG > REPEAT > RELEASE. This guarantees PRESS precedes RELEASE for the same key.
  - Latency from the FSM raising an event to evt_valid, with the output idle: 2 clk.
- level is registered directly from FSM state (1 in HELD, LONG and RELEASE_WAIT).

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined: the LONG state generates REPEAT every REPEAT_TICKS ticks while held.
- Undefined:
  - LONG stays silent until release;
  - the REPEAT pending bits and the REPEAT_TICKS comparison are not built;
  - code 3 is never emitted.

Decomposition:
- Package key_event_pkg holds:
  - typedef enum logic [1:0] evt_code_t (EVT_PRESS, EVT_RELEASE, EVT_LONG, EVT_REPEAT);
  - typedef enum key_state_t (IDLE, PRESS_WAIT, HELD, LONG, RELEASE_WAIT).
- Sub-module key_fsm contains one key's synchroniser, FSM, cnt and level.
  - It takes clk, reset, sw_raw and tick, and outputs level and 4 one-cycle event strobes.
  - The top instantiates it NUM_KEYS times, alongside the shared prescaler, the pending store and the arbiter.

Test Plan (TICK_DIV=4, i.e. tick every 16 clk; DB_TICKS=3; LONG_TICKS=4; REPEAT_TICKS=2; NUM_KEYS=4):
- sw[0] pulses high for 20 cycles, then low -> level stays 0, no evt_valid, ovf=0.
- sw[1] held high 200 cycles with evt_ready=1:
  - level[1] rises between 32 and 48 cycles after the sync delay;
  - one PRESS (key 1, code 0);
  - LONG 64 cycles after PRESS;
  - with KEY_AUTO_REPEAT_EN, REPEAT every 32 cycles.
- sw[1] released -> level falls after 32-48 cycles, then RELEASE (key 1, code 1) is emitted; no other events.
- sw[0] and sw[2] pressed on the same cycle, evt_ready=1 -> events for key 0 then key 2 on consecutive cycles. A repeat with the grant pointer at key 0 gives key 2 first, then key 0.
- evt_ready=0 while sw[3] does press, release, press:
  - outputs hold key 3 PRESS stable;
  - the second PRESS sets ovf[3]=1;
  - on releasing ready, events drain back-to-back as PRESS then RELEASE.
- reset asserted mid-PRESS_WAIT and while evt_valid=1 -> all outputs 0 asynchronously; after deassert no stale event appears.
